// File: rtl/object_package.sv
// rtl/object_package.sv - shared match-state encoding and default game constants
package object_package;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_PAUSE    = 3'd3,
    S_GAMEOVER = 3'd4
  } game_state_t;

  localparam int WIN_SCORE_DEF   = 5;
  localparam int SERVE_DELAY_DEF = 60;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - rising-edge detector; pulse is high for the first clk a level is seen high
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - match sequencer: serve delay, scoring, pause and restart
module game_ctrl
  import object_package::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int SW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          btn_start,
  input  logic          miss_left,
  input  logic          miss_right,
  output logic          play_en,
  output logic          serve,
  output logic          serve_dir,
  output logic [SW-1:0] score_l,
  output logic [SW-1:0] score_r,
  output logic          gameover,
  output logic [2:0]    state_o
);

  localparam logic [7:0]    DELAY_LD = 8'(SERVE_DELAY);
  localparam logic [SW-1:0] WIN_VAL  = SW'(WIN_SCORE);

  game_state_t   state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [SW-1:0] score_l_n, score_r_n;
  logic          serve_n, serve_dir_n, play_en_n, gameover_n;
  logic          start_edge;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == {SW{1'b1}}) ? v : v + 1'b1;
  endfunction

  edge_rise u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (btn_start),
    .pulse (start_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      score_l   <= '0;
      score_r   <= '0;
      serve     <= 1'b0;
      serve_dir <= 1'b0;
      play_en   <= 1'b0;
      gameover  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score_l   <= score_l_n;
      score_r   <= score_r_n;
      serve     <= serve_n;
      serve_dir <= serve_dir_n;
      play_en   <= play_en_n;
      gameover  <= gameover_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    score_l_n   = score_l;
    score_r_n   = score_r;
    serve_dir_n = serve_dir;
    serve_n     = 1'b0;
    case (state)
      S_IDLE, S_GAMEOVER: begin
        if (start_edge) begin
          score_l_n   = '0;
          score_r_n   = '0;
          cnt_n       = DELAY_LD;
          serve_dir_n = 1'b1;
          state_n     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt > 8'd1) begin
            cnt_n = cnt - 8'd1;
          end else begin
            cnt_n   = '0;
            serve_n = 1'b1;
            state_n = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        // A miss takes priority over a pause request in the same clk.
        if (miss_left || miss_right) begin
          if (miss_left && !miss_right) begin
            score_r_n   = sat_inc(score_r);
            serve_dir_n = 1'b0;
          end else if (miss_right && !miss_left) begin
            score_l_n   = sat_inc(score_l);
            serve_dir_n = 1'b1;
          end
          if (score_l_n == WIN_VAL || score_r_n == WIN_VAL) begin
            state_n = S_GAMEOVER;
          end else begin
            cnt_n   = DELAY_LD;
            state_n = S_SERVE;
          end
        end else if (start_edge) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_edge) state_n = S_PLAY;
      end
      default: begin
        state_n     = S_IDLE;
        cnt_n       = '0;
        score_l_n   = '0;
        score_r_n   = '0;
        serve_dir_n = 1'b0;
      end
    endcase
    play_en_n  = (state_n == S_PLAY);
    gameover_n = (state_n == S_GAMEOVER);
  end

  assign state_o = state;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       play_en, serve, serve_dir, gameover;
  logic [3:0] score_l, score_r;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int serve_seen;

  game_ctrl #(.WIN_SCORE(5), .SERVE_DELAY(60), .SW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_start  (btn_start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .play_en    (play_en),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .score_l    (score_l),
    .score_r    (score_r),
    .gameover   (gameover),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic press();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
  endtask

  initial begin
    #23;
    check("reset_state", state_o, 0);
    check("reset_play_en", play_en, 0);
    check("reset_serve", serve, 0);
    check("reset_dir", serve_dir, 0);
    check("reset_gameover", gameover, 0);
    check("reset_scores", {score_l, score_r}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic serve: held button gives one edge
    btn_start = 1'b1;
    step();
    check("start_state", state_o, 1);
    check("start_play_en", play_en, 0);
    check("start_dir", serve_dir, 1);
    for (int i = 0; i < 9; i++) step();
    check("held_state", state_o, 1);
    btn_start = 1'b0;
    ticks(59);
    check("pre_serve_state", state_o, 1);
    check("pre_serve_pulse", serve, 0);
    ticks(1);
    check("serve_pulse", serve, 1);
    check("serve_play_en", play_en, 1);
    check("serve_dir1", serve_dir, 1);
    check("play_state", state_o, 2);
    step();
    check("serve_one_clk", serve, 0);
    check("play_en_hold", play_en, 1);

    // Scoring: left miss
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    check("ml_score_r", score_r, 1);
    check("ml_score_l", score_l, 0);
    check("ml_dir", serve_dir, 0);
    check("ml_state", state_o, 1);
    check("ml_play_en", play_en, 0);
    ticks(60);
    check("ml_serve", serve, 1);
    check("ml_serve_dir", serve_dir, 0);
    step();

    // Simultaneous misses replay the point
    miss_left = 1'b1;
    miss_right = 1'b1;
    step();
    miss_left = 1'b0;
    miss_right = 1'b0;
    check("both_scores", {score_l, score_r}, 8'h01);
    check("both_state", state_o, 1);
    check("both_dir", serve_dir, 0);
    ticks(60);
    check("both_serve", serve, 1);

    // Pause
    btn_start = 1'b1;
    step();
    check("pause_state", state_o, 3);
    check("pause_play_en", play_en, 0);
    btn_start = 1'b0;
    step();
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    check("pause_miss_ignored", {score_l, score_r}, 8'h01);
    check("pause_miss_state", state_o, 3);
    btn_start = 1'b1;
    step();
    check("resume_state", state_o, 2);
    check("resume_play_en", play_en, 1);
    check("resume_scores", {score_l, score_r}, 8'h01);
    btn_start = 1'b0;
    step();
    btn_start = 1'b1;
    miss_right = 1'b1;
    step();
    btn_start = 1'b0;
    miss_right = 1'b0;
    check("miss_beats_pause_l", score_l, 1);
    check("miss_beats_pause_state", state_o, 1);
    check("mr_dir", serve_dir, 1);
    ticks(60);
    check("mr_serve", serve, 1);
    step();

    // Win: score_l goes 1 -> 5
    for (int k = 2; k <= 5; k++) begin
      miss_right = 1'b1;
      step();
      miss_right = 1'b0;
      check("win_score_l", score_l, k);
      if (k < 5) begin
        check("win_mid_state", state_o, 1);
        ticks(60);
        check("win_mid_serve", serve, 1);
        step();
      end
    end
    check("win_gameover", gameover, 1);
    check("win_play_en", play_en, 0);
    check("win_state", state_o, 4);
    step();
    check("win_hold", state_o, 4);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    check("restart_scores", {score_l, score_r}, 0);
    check("restart_gameover", gameover, 0);
    check("restart_state", state_o, 1);
    check("restart_dir", serve_dir, 1);

    // Async reset mid-SERVE with cnt=30
    ticks(30);
    check("pre_rst_state", state_o, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_state", state_o, 0);
    check("arst_dir", serve_dir, 0);
    check("arst_play_en", play_en, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    serve_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (serve) serve_seen++;
    end
    check("post_rst_no_serve", serve_seen, 0);
    check("post_rst_state", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Match-level sequencer that sits directly upstream of the paddle stages (user paddle, AI paddle) and the ball stage.
- Produces the `play_en` term that gates every per-frame object update. Together with the gameover flag and video valid, it forms the paddles' `en`.
- Consumes ball exit events, keeps both scores, times the serve delay in frame ticks, and handles start/pause/restart from the start button.

Parameters:
- WIN_SCORE, 5, points needed to win; range 1..15.
- SERVE_DELAY, 60, frame ticks spent frozen in SERVE before the ball is released; range 1..255.
- SW, 4, score counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- tick  input  1  one-cycle pulse per video frame
- btn_start  input  1  debounced start/pause level
- miss_left  input  1  one-cycle pulse: ball left the screen past the left paddle
- miss_right  input  1  one-cycle pulse: ball left the screen past the right paddle
- play_en  output  1  object updates enabled
- serve  output  1  one-cycle pulse: ball re-centres and launches
- serve_dir  output  1  launch direction: 0 = toward left player, 1 = toward right player
- score_l  output  SW  left player score
- score_r  output  SW  right player score
- gameover  output  1  match finished
- state_o  output  3  current state encoding, for the display/debug overlay

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - play_en=0, serve=0, serve_dir=0, gameover=0.
  - score_l=0, score_r=0.
  - delay counter=0; start edge register=0.
- start_edge = btn_start & ~btn_start_q, where btn_start_q is registered every clk. A held button yields exactly one edge.
- All outputs are registered and update one clk after the causing input.
- States: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, GAMEOVER=4.
- IDLE:
  - play_en=0.
  - start_edge: clear both scores, load cnt=SERVE_DELAY, set serve_dir=1, go to SERVE.
- SERVE:
  - play_en=0.
  - On tick with cnt>1: cnt-1.
  - On tick with cnt==1: cnt=0, serve=1 for exactly one clk, go to PLAY; play_en=1 in the same cycle serve is high.
  - Misses and start_edge are ignored.
- PLAY:
  - play_en=1.
  - miss_left only: score_r+1, serve_dir=0 (the loser receives the serve).
  - miss_right only: score_l+1, serve_dir=1.
  - miss_left and miss_right in the same clk: no score change, serve_dir unchanged, replay the point.
  - After any miss:
    - if the updated score equals WIN_SCORE, go to GAMEOVER;
    - otherwise load cnt=SERVE_DELAY and go to SERVE.
  - start_edge with no miss: go to PAUSE.
  - start_edge in the same clk as a miss: the miss wins and start_edge is dropped.
- PAUSE:
  - play_en=0.
  - Misses are ignored.
  - start_edge: go to PLAY.
  - Scores and cnt are held.
- GAMEOVER:
  - gameover=1, play_en=0.
  - start_edge: clear scores, gameover=0, cnt=SERVE_DELAY, serve_dir=1, go to SERVE.
- Scores saturate at 2^SW-1; they cannot wrap because WIN_SCORE is at most 15.
- The tick counter only counts in SERVE. A tick arriving in the same clk as the state entry is not counted.
- Illegal state encodings (5–7) recover to IDLE on the next clk with all outputs at their reset values.
- Reset mid-match: all state is cleared immediately, and a serve pulse in flight is cut.

Decomposition:
- Shared package object_package gains:
  - typedef enum logic [2:0] game_state_t with the five states above;
  - constants WIN_SCORE_DEF=5 and SERVE_DELAY_DEF=60.
  The display and ball stages import these.
- One sub-module, edge_rise (clk, rst, d -> pulse), supplies start_edge. It is reused later for other button edges.
- The FSM, counter and scores stay in game_ctrl.

Test Plan:
- Basic serve:
  - Stimulus: reset, then btn_start held 1 for 10 clks.
  - Response: exactly one edge, state=SERVE, play_en=0.
  - Stimulus: 60 ticks.
  - Response: serve=1 for one clk after the 60th tick, play_en=1, serve_dir=1.
- Scoring:
  - Stimulus: in PLAY, miss_left pulse.
  - Response: score_r=1, serve_dir=0, state=SERVE, play_en=0.
  - Stimulus: 60 ticks.
  - Response: serve pulse.
- Simultaneous misses:
  - Stimulus: miss_left and miss_right in the same clk.
  - Response: scores unchanged, state=SERVE.
- Win:
  - Stimulus: five miss_right pulses, each separated by full serve delays.
  - Response: score_l=5, gameover=1, play_en=0.
  - Stimulus: start_edge.
  - Response: scores=0, gameover=0, state=SERVE.
- Pause:
  - Stimulus: start_edge in PLAY.
  - Response: PAUSE, play_en=0.
  - Stimulus: miss_left while paused.
  - Response: ignored.
  - Stimulus: start_edge.
  - Response: PLAY with scores unchanged.
  - Stimulus: start_edge in the same clk as miss_right.
  - Response: score_l+1, state=SERVE (not PAUSE).
- Async reset:
  - Stimulus: assert rst mid-SERVE with cnt=30, between clk edges.
  - Response: outputs reach reset values before the next edge; after release, state=IDLE and no serve pulse appears.
